thumb_inst_fetch: RTL and testbench

Instruction fetch front-end for the ARM core. It issues word reads to instruction memory and splits each returned word into Thumb halfwords. It detects 32-bit Thumb-2 encodings, assembles them, and hands one complete instruction per handshake to the decoder (IT/pre-decode stage). It sits between the instruction memory port and the core's instruction input and is the producing end of the instruction stream the core consumes.

---
 rtl/thumb_inst_fetch.sv | 168 ++++++++++++++++
 tb/tb_thumb_inst_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_inst_fetch.sv
// rtl/thumb_inst_fetch.sv - Thumb instruction fetch: word reads, halfword buffer, 16/32-bit assembly
module thumb_inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          HW_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic [31:0] inst,
  output logic        inst_is32,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

  localparam int PW = $clog2(HW_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FREE = CW'(HW_DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  logic [15:0]   r_hw [HW_DEPTH];
  logic [31:1]   r_pc [HW_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_mem_req;
  logic          r_discard;
  logic          r_out_hi;
  logic [31:2]   r_out_word;
  logic [31:1]   r_fa;

  logic [PW-1:0] w_rd_ptr1;
  logic [PW-1:0] w_wr_ptr1;
  logic [15:0]   w_head_hw;
  logic [15:0]   w_next_hw;
  logic          w_head_is32;
  logic          w_valid;
  logic          w_pop;
  logic [1:0]    w_pop_n;
  logic          w_push;
  logic [1:0]    w_push_n;
  logic [CW-1:0] w_count_nxt;
  logic          w_unused;

  assign w_unused  = flush_addr[0];
  assign w_rd_ptr1 = r_rd_ptr + PTR_ONE;
  assign w_wr_ptr1 = r_wr_ptr + PTR_ONE;
  assign w_head_hw = r_hw[r_rd_ptr];
  assign w_next_hw = r_hw[w_rd_ptr1];

  // 32-bit Thumb-2 prefixes are 0b11101, 0b11110 and 0b11111
  assign w_head_is32 = (w_head_hw[15:13] == 3'b111) && (w_head_hw[12:11] != 2'b00);
  assign w_valid     = (r_count >= CNT_ONE) && (!w_head_is32 || (r_count >= CNT_TWO));

  assign w_pop    = w_valid && inst_ready && !flush;
  assign w_pop_n  = w_pop ? (w_head_is32 ? 2'd2 : 2'd1) : 2'd0;
  assign w_push   = (r_state == S_WAIT) && mem_rvalid && !r_discard;
  assign w_push_n = w_push ? (r_out_hi ? 2'd1 : 2'd2) : 2'd0;
  assign w_count_nxt = r_count + CW'(w_push_n) - CW'(w_pop_n);

  assign inst_valid = w_valid;
  assign inst_is32  = w_head_is32;
  assign inst       = w_head_is32 ? {w_head_hw, w_next_hw} : {w_head_hw, 16'h0000};
  assign inst_pc    = {r_pc[r_rd_ptr], 1'b0};
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_req ? {r_fa[31:2], 2'b00} : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HW_DEPTH; i++) begin
        r_hw[i] <= '0;
        r_pc[i] <= '0;
      end
    end else if (w_push && !flush) begin
      if (r_out_hi) begin
        r_hw[r_wr_ptr] <= mem_rdata[31:16];
        r_pc[r_wr_ptr] <= {r_out_word, 1'b1};
      end else begin
        r_hw[r_wr_ptr]  <= mem_rdata[15:0];
        r_pc[r_wr_ptr]  <= {r_out_word, 1'b0};
        r_hw[w_wr_ptr1] <= mem_rdata[31:16];
        r_pc[w_wr_ptr1] <= {r_out_word, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_discard  <= 1'b0;
      r_out_hi   <= 1'b0;
      r_out_word <= '0;
      r_fa       <= RESET_ADDR[31:1];
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fa     <= flush_addr[31:1];
      // A grant in this same cycle still produces a response that must be dropped
      if (((r_state == S_WAIT) && !mem_rvalid) || ((r_state == S_REQ) && mem_gnt)) begin
        r_discard <= 1'b1;
        r_state   <= S_WAIT;
        r_mem_req <= 1'b0;
      end else begin
        r_discard <= 1'b0;
        r_state   <= S_REQ;
        r_mem_req <= 1'b1;
      end
    end else begin
      r_count  <= w_count_nxt;
      r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
      case (r_state)
        S_IDLE: begin
          if (r_count <= CNT_FREE) begin
            r_state   <= S_REQ;
            r_mem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            r_state    <= S_WAIT;
            r_mem_req  <= 1'b0;
            r_out_word <= r_fa[31:2];
            r_out_hi   <= r_fa[1];
            r_fa       <= {r_fa[31:2] + 30'd1, 1'b0};
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_discard <= 1'b0;
            if (r_discard || (w_count_nxt <= CNT_FREE)) begin
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thumb_inst_fetch.sv
// tb/tb_thumb_inst_fetch.sv - scoreboard bench for thumb_inst_fetch
module tb_thumb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic [31:0] flush_addr;
  logic [31:0] inst;
  logic        inst_is32;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  thumb_inst_fetch #(.RESET_ADDR(32'h0000_0000), .HW_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .flush(flush), .flush_addr(flush_addr),
    .inst(inst), .inst_is32(inst_is32), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        is32;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:127];
  logic [31:0] gaddr[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          lat = 1;
  int          gcount = 0;
  int          nrv = 0;
  int          cyc = 0;
  int          grant_cyc = -1;
  int          first_valid_cyc = -1;
  int          first_is32_nrv = -1;
  logic        busy = 1'b0;
  logic        ready_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [31:0] i, input logic is32, input logic [31:0] pc);
    exp_t e;
    e.inst = i;
    e.is32 = is32;
    e.pc   = pc;
    sb.push_back(e);
  endtask

  // Memory responder: grant seen before the edge, rvalid lat cycles after it
  initial begin
    logic        gnt_now;
    logic [31:0] a;
    logic [31:0] paddr;
    int          cnt;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    paddr      = 32'h0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      gnt_now = mem_req && mem_gnt;
      a       = mem_addr;
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        gcount = 0;
        nrv = 0;
        grant_cyc = -1;
        gaddr.delete();
      end
      if (gnt_now) begin
        if (gcount == 0) grant_cyc = cyc - 1;
        gcount++;
        gaddr.push_back(a);
        busy  = 1'b1;
        cnt   = lat;
        paddr = a;
      end
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy       = 1'b0;
          mem_rvalid = 1'b1;
          mem_rdata  = mem[paddr[8:2]];
          nrv++;
        end
      end
    end
  end

  initial begin
    inst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      inst_ready = ready_en && (sb.size() > 0);
    end
  end

  // Monitor: compare every accepted instruction against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        first_valid_cyc = -1;
        first_is32_nrv  = -1;
      end else if (inst_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_is32 && first_is32_nrv < 0) first_is32_nrv = nrv - (mem_rvalid ? 1 : 0);
        if (inst_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_inst", inst, 32'hxxxx_xxxx);
          end else begin
            e = sb.pop_front();
            chk("inst", inst, e.inst);
            chk("inst_is32", {31'b0, inst_is32}, {31'b0, e.is32});
            chk("inst_pc", inst_pc, e.pc);
          end
        end
      end
    end
  end

  task automatic do_reset;
    int n;
    mem_gnt  = 1'b0;
    ready_en = 1'b0;
    flush    = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 128; i++) mem[i] = 32'hBF00_BF00;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grants(input int want);
    int n;
    n = 0;
    while (gcount < want && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("grant_wait", gcount, want);
  endtask

  initial begin
    int n;
    int nv;
    rst_n      = 1'b1;
    mem_gnt    = 1'b0;
    flush      = 1'b0;
    flush_addr = 32'h0;

    // Basic 16-bit stream and reset state
    do_reset();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_is32", {31'b0, inst_is32}, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    mem[0] = 32'hBF08_2001;
    mem[1] = 32'h4770_BF00;
    push_exp(32'h2001_0000, 1'b0, 32'h0);
    push_exp(32'hBF08_0000, 1'b0, 32'h2);
    push_exp(32'hBF00_0000, 1'b0, 32'h4);
    push_exp(32'h4770_0000, 1'b0, 32'h6);
    lat = 1;
    mem_gnt = 1'b1;
    ready_en = 1'b1;
    rst_n = 1'b1;
    wait_drain(60);
    chk("addr0", (gaddr.size() > 0) ? gaddr[0] : 32'hFFFF_FFFF, 32'h0);
    chk("addr1", (gaddr.size() > 1) ? gaddr[1] : 32'hFFFF_FFFF, 32'h4);
    chk("latency", first_valid_cyc - grant_cyc, 2);

    // 32-bit instruction split across two words
    do_reset();
    mem[0] = 32'hF000_2000;
    mem[1] = 32'h4770_F800;
    push_exp(32'h2000_0000, 1'b0, 32'h0);
    push_exp(32'hF000_F800, 1'b1, 32'h2);
    push_exp(32'h4770_0000, 1'b0, 32'h6);
    mem_gnt = 1'b1;
    ready_en = 1'b1;
    rst_n = 1'b1;
    wait_drain(60);
    chk("split_words_before_valid", first_is32_nrv, 2);

    // Consumer stalled: buffer fills and requests stop
    do_reset();
    mem[0] = 32'hBF08_2001;
    mem[1] = 32'h4770_BF00;
    push_exp(32'h2001_0000, 1'b0, 32'h0);
    push_exp(32'hBF08_0000, 1'b0, 32'h2);
    push_exp(32'hBF00_0000, 1'b0, 32'h4);
    push_exp(32'h4770_0000, 1'b0, 32'h6);
    mem_gnt = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("full_grants", gcount, 2);
    chk("full_mem_req", {31'b0, mem_req}, 32'd0);
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    chk("full_inst", inst, 32'h2001_0000);
    repeat (5) @(posedge clk);
    #2;
    chk("full_inst_hold", inst, 32'h2001_0000);
    chk("full_grants_hold", gcount, 2);
    ready_en = 1'b1;
    wait_drain(60);

    // Flush to a misaligned target while a read is outstanding
    do_reset();
    mem[0]  = 32'h2001_2001;
    mem[65] = 32'h4770_BF08;
    mem[66] = 32'h2001_BF00;
    push_exp(32'h4770_0000, 1'b0, 32'h106);
    push_exp(32'hBF00_0000, 1'b0, 32'h108);
    push_exp(32'h2001_0000, 1'b0, 32'h10A);
    lat = 3;
    mem_gnt = 1'b1;
    ready_en = 1'b1;
    rst_n = 1'b1;
    wait_grants(1);
    flush_addr = 32'h0000_0106;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    wait_drain(100);
    chk("flush_addr", (gaddr.size() > 1) ? gaddr[1] : 32'hFFFF_FFFF, 32'h104);

    // Asynchronous reset during WAIT, then a stray response
    do_reset();
    lat = 3;
    mem_gnt = 1'b1;
    rst_n = 1'b1;
    wait_grants(1);
    rst_n = 1'b0;
    #1;
    chk("async_mem_req", {31'b0, mem_req}, 32'd0);
    chk("async_mem_addr", mem_addr, 32'd0);
    chk("async_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("async_inst", inst, 32'd0);
    chk("async_inst_pc", inst_pc, 32'd0);
    mem_gnt = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    n = 0;
    nv = 0;
    while (n < 10) begin
      @(negedge clk);
      if (inst_valid) nv++;
      n++;
    end
    chk("stray_rvalid_seen", nrv, 1);
    chk("stray_valid", nv, 0);

    // Simultaneous push and pop at count 2, then a sustained 16-bit stream
    do_reset();
    for (int w = 0; w < 8; w++) mem[w] = {16'h2000 + 16'(4*w+2), 16'h2000 + 16'(4*w)};
    for (int k = 0; k < 16; k++) push_exp({16'h2000 + 16'(2*k), 16'h0000}, 1'b0, 32'(2*k));
    lat = 1;
    mem_gnt = 1'b1;
    rst_n = 1'b1;
    n = 0;
    while (nrv < 1 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #2;
    ready_en = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("push_pop_count", 32'(dut.r_count), 32'd3);
    wait_drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
